bcd_digit_entry: RTL and testbench
==================================

Name: bcd_digit_entry

Overview:
- Downstream stage of the decimal-to-BCD key encoder: consumes its 4-bit BCD code plus a "key down" level (OR of the 10 one-hot key lines, generated at top level).
- Debounces the key, captures one digit per press into a 4-digit shift register, and drives a multiplexed 4-digit active-low 7-segment display.
- Sits between the keypad encoder and the board display pins.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a press or a release (10 ms at 50 MHz). Must be ≥2.
- REFRESH_CYCLES, 50000, clock cycles each digit stays lit during display multiplexing. Must be ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd_in  input  4  BCD digit from the encoder; meaningful only while key_valid=1.
- key_valid  input  1  raw, undebounced, asynchronous "any key pressed" level.
- clear  input  1  synchronous clear of entered digits.
- digits_out  output  16  four BCD digits; [3:0] is the newest, [15:12] the oldest.
- entry_count  output  3  number of digits entered, 0..4, saturating.
- digit_strobe  output  1  one-cycle pulse when a digit is accepted.
- overflow  output  1  sticky flag: a digit was entered while entry_count=4.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an_n  output  4  digit anodes, active-low one-hot; an_n[0] is the rightmost (newest) digit.

Behaviour:
- Reset values: digits_out=0, entry_count=0, digit_strobe=0, overflow=0, seg_n=7'b1111111, an_n=4'b1110, FSM=IDLE, all counters 0.
- key_valid passes through a 2-flop synchronizer (reset 0). All FSM decisions use the synchronized value ks.
- Debounce FSM:
  - IDLE: ks=1 → PRESS_CHK, counter=0.
  - PRESS_CHK: ks=0 → IDLE. Otherwise count. When counter reaches DEBOUNCE_CYCLES-1 with ks=1, go to HELD and capture bcd_in in the same cycle.
  - HELD: ks=0 → REL_CHK, counter=0.
  - REL_CHK: ks=1 → HELD. When counter reaches DEBOUNCE_CYCLES-1 with ks=0, go to IDLE.
- One press yields exactly one digit, regardless of hold time or bounce.
- Capture:
  - On the capture cycle, bcd_in ≤ 9: the next edge sets digits_out <= {digits_out[11:0], bcd_in}, pulses digit_strobe for 1 cycle, and increments entry_count (saturating at 4).
  - If entry_count was already 4, the oldest digit is discarded and overflow is set.
  - bcd_in > 9: press ignored, no strobe, FSM still goes to HELD.
- clear: has priority over a simultaneous capture. The next edge gives digits_out=0, entry_count=0, overflow=0, digit_strobe=0. The FSM is not affected, so a key still held does not re-enter a digit.
- Reset mid-press: asynchronous return to reset values. After release, the FSM requires a fresh full debounced press.
- Display:
  - A refresh counter counts 0..REFRESH_CYCLES-1, then wraps and advances a 2-bit select sel 0→1→2→3→0.
  - an_n = ~(4'b0001 << sel).
  - seg_n is the registered decode of digits_out[4*sel+3 -: 4], updated in the same cycle as an_n.
  - Position sel is blanked (seg_n=7'b1111111) when sel ≥ entry_count, so leading unused positions stay dark and everything is blank when entry_count=0.
- Segment codes (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other value shows blank.
- Latency: key_valid rising → digit_strobe = 2 (synchronizer) + DEBOUNCE_CYCLES + 1 cycles, ±1.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - the FSM state enum (IDLE, PRESS_CHK, HELD, REL_CHK);
  - the SEG_0..SEG_9 and SEG_BLANK constants;
  - the NUM_DIGITS=4 constant.
- One natural sub-module: bcd_to_seg7, a combinational 4-bit BCD to 7-bit active-low segment decoder, also reusable elsewhere.

Test Plan (DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8):
- Reset then idle 100 cycles → digits_out=0, entry_count=0, an_n cycles 1110→1101→1011→0111 every 8 cycles, seg_n=1111111 throughout.
- Clean press bcd_in=5, key_valid held 20 cycles, then released 20 cycles → exactly one digit_strobe; digits_out=16'h0005, entry_count=1; when an_n=1110, seg_n=0010010; other positions blank.
- Bouncy press: key_valid toggles 1,0,1,0 with 1-cycle pulses, then stable high 10 cycles with bcd_in=7 → one strobe only, digits_out[3:0]=7; a 2-cycle glitch low during HELD does not generate a second digit.
- Enter 1,2,3,4,9 with full press/release each → after the 4th digit, digits_out=16'h1234, overflow=0; after the 5th, digits_out=16'h2349, entry_count=4, overflow=1.
- clear asserted on the same cycle as a capture of digit 8, starting from 16'h0012 → digits_out=0, entry_count=0, no strobe; the key still held yields no digit until it is released and pressed again.
- rst_n pulsed low during PRESS_CHK and during HELD → outputs return to reset values immediately (asynchronously); a subsequent full press of 3 gives digits_out=16'h0003.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the keypad digit entry and 7-segment display path.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } deb_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_digit_entry_if.sv
// Keypad-side inputs and entry/display outputs of the digit entry block.
// master drives the key inputs; slave is the entry block itself.
interface bcd_digit_entry_if;
    logic [3:0]  bcd_in;
    logic        key_valid;
    logic        clear;
    logic [15:0] digits_out;
    logic [2:0]  entry_count;
    logic        digit_strobe;
    logic        overflow;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;

    modport master (
        output bcd_in, key_valid, clear,
        input  digits_out, entry_count, digit_strobe, overflow, seg_n, an_n
    );

    modport slave (
        input  bcd_in, key_valid, clear,
        output digits_out, entry_count, digit_strobe, overflow, seg_n, an_n
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show blank.
// Zero latency, no flow control.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_digit_entry.sv
// Debounced keypad digit entry into a 4-digit shift register with a multiplexed 7-seg display.
// Key rise to strobe is 2 + DEBOUNCE_CYCLES + 1 cycles; no backpressure, one digit per press.
module bcd_digit_entry
    import bcd_disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_digit_entry_if.slave bus
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES);
    localparam int RCW = $clog2(REFRESH_CYCLES);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_CYCLES - 1);

    logic                  ks_meta_q;
    logic                  ks_q;
    deb_state_e            state_q;
    logic [DCW-1:0]        deb_cnt_q;
    logic                  capture;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [2:0]              count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    strobe_q, strobe_d;

    logic [RCW-1:0]        ref_q, ref_d;
    logic [1:0]            sel_q, sel_d;
    logic [3:0]            nibble;
    logic [6:0]            seg_raw;
    logic [6:0]            seg_n_q, seg_n_d;
    logic [3:0]            an_n_q, an_n_d;

    // key_valid is asynchronous to clk; only ks_q may steer the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_meta_q <= 1'b0;
            ks_q      <= 1'b0;
        end else begin
            ks_meta_q <= bus.key_valid;
            ks_q      <= ks_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ks_q) begin
                        state_q   <= PRESS_CHK;
                        deb_cnt_q <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!ks_q)
                        state_q <= IDLE;
                    else if (deb_cnt_q == DEB_LAST)
                        state_q <= HELD;
                    else
                        deb_cnt_q <= deb_cnt_q + DCW'(1);
                end
                HELD: begin
                    if (!ks_q) begin
                        state_q   <= REL_CHK;
                        deb_cnt_q <= '0;
                    end
                end
                REL_CHK: begin
                    if (ks_q)
                        state_q <= HELD;
                    else if (deb_cnt_q == DEB_LAST)
                        state_q <= IDLE;
                    else
                        deb_cnt_q <= deb_cnt_q + DCW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The only cycle in which a press is turned into a digit.
    assign capture = (state_q == PRESS_CHK) && ks_q && (deb_cnt_q == DEB_LAST);

    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        strobe_d = 1'b0;
        if (bus.clear) begin
            digits_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else if (capture && (bus.bcd_in <= 4'd9)) begin
            digits_d = {digits_q[4*NUM_DIGITS-5:0], bus.bcd_in};
            strobe_d = 1'b1;
            if (count_q == 3'(NUM_DIGITS))
                ovf_d = 1'b1;
            else
                count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            digits_q <= digits_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        ref_d = ref_q + RCW'(1);
        sel_d = sel_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            sel_d = sel_q + 2'd1;
        end
    end

    // Decode from next-state values so anode, segments and digit contents change together.
    assign nibble = digits_d[{sel_d, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd_i   (nibble),
        .seg_n_o (seg_raw)
    );

    always_comb begin
        an_n_d  = ~(4'b0001 << sel_d);
        seg_n_d = ({1'b0, sel_d} >= count_d) ? SEG_BLANK : seg_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q   <= '0;
            sel_q   <= '0;
            seg_n_q <= SEG_BLANK;
            an_n_q  <= 4'b1110;
        end else begin
            ref_q   <= ref_d;
            sel_q   <= sel_d;
            seg_n_q <= seg_n_d;
            an_n_q  <= an_n_d;
        end
    end

    assign bus.digits_out   = digits_q;
    assign bus.entry_count  = count_q;
    assign bus.digit_strobe = strobe_q;
    assign bus.overflow     = ovf_q;
    assign bus.seg_n        = seg_n_q;
    assign bus.an_n         = an_n_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed bench for bcd_digit_entry with DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8.
module tb_bcd_digit_entry;

    logic clk = 1'b0;
    logic rst_n;
    int   chk_cnt    = 0;
    int   pass_cnt   = 0;
    int   strobe_cnt = 0;

    always #5 clk = ~clk;

    bcd_digit_entry_if bus();

    bcd_digit_entry #(
        .DEBOUNCE_CYCLES (4),
        .REFRESH_CYCLES  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) if (bus.digit_strobe === 1'b1) strobe_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input int hold, input int rel);
        bus.bcd_in    = d;
        bus.key_valid = 1'b1;
        tick(hold);
        bus.key_valid = 1'b0;
        tick(rel);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        tick(1);
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        chk_cnt++; if (bus.digits_out !== 16'h0) $display("FAIL %s digits_out got %h want 0000", tag, bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd0) $display("FAIL %s entry_count got %0d want 0", tag, bus.entry_count); else pass_cnt++;
        chk_cnt++; if (bus.digit_strobe !== 1'b0) $display("FAIL %s digit_strobe got %b want 0", tag, bus.digit_strobe); else pass_cnt++;
        chk_cnt++; if (bus.overflow !== 1'b0) $display("FAIL %s overflow got %b want 0", tag, bus.overflow); else pass_cnt++;
        chk_cnt++; if (bus.seg_n !== 7'b1111111) $display("FAIL %s seg_n got %b want 1111111", tag, bus.seg_n); else pass_cnt++;
        chk_cnt++; if (bus.an_n !== 4'b1110) $display("FAIL %s an_n got %b want 1110", tag, bus.an_n); else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        rst_n         = 1'b0;
        bus.bcd_in    = 4'd0;
        bus.key_valid = 1'b0;
        bus.clear     = 1'b0;
        tick(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            exp_an = ~(4'b0001 << ((k / 8) % 4));
            chk_cnt++; if (bus.an_n !== exp_an) $display("FAIL idle_an cyc %0d got %b want %b", k, bus.an_n, exp_an); else pass_cnt++;
            chk_cnt++; if (bus.seg_n !== 7'b1111111) $display("FAIL idle_seg cyc %0d got %b want 1111111", k, bus.seg_n); else pass_cnt++;
        end
        chk_cnt++; if (bus.digits_out !== 16'h0) $display("FAIL idle_digits got %h want 0000", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd0) $display("FAIL idle_count got %0d want 0", bus.entry_count); else pass_cnt++;
    endtask

    task automatic test_clean_press();
        int  s0;
        int  seen;
        logic [6:0] exp_seg;
        s0   = strobe_cnt;
        seen = 0;
        press(4'd5, 20, 20);
        chk_cnt++; if (strobe_cnt - s0 !== 1) $display("FAIL clean_strobes got %0d want 1", strobe_cnt - s0); else pass_cnt++;
        chk_cnt++; if (bus.digits_out !== 16'h0005) $display("FAIL clean_digits got %h want 0005", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd1) $display("FAIL clean_count got %0d want 1", bus.entry_count); else pass_cnt++;
        for (int k = 0; k < 32; k++) begin
            tick(1);
            exp_seg = (bus.an_n == 4'b1110) ? 7'b0010010 : 7'b1111111;
            if (bus.an_n == 4'b1110) seen++;
            chk_cnt++; if (bus.seg_n !== exp_seg) $display("FAIL clean_seg an %b got %b want %b", bus.an_n, bus.seg_n, exp_seg); else pass_cnt++;
        end
        chk_cnt++; if (seen !== 8) $display("FAIL clean_an0_cycles got %0d want 8", seen); else pass_cnt++;
    endtask

    task automatic test_bounce();
        int s0;
        s0 = strobe_cnt;
        bus.bcd_in = 4'd7;
        bus.key_valid = 1'b1; tick(1);
        bus.key_valid = 1'b0; tick(1);
        bus.key_valid = 1'b1; tick(1);
        bus.key_valid = 1'b0; tick(1);
        bus.key_valid = 1'b1; tick(10);
        chk_cnt++; if (strobe_cnt - s0 !== 1) $display("FAIL bounce_strobes got %0d want 1", strobe_cnt - s0); else pass_cnt++;
        bus.key_valid = 1'b0; tick(2);
        bus.key_valid = 1'b1; tick(10);
        bus.key_valid = 1'b0; tick(20);
        chk_cnt++; if (strobe_cnt - s0 !== 1) $display("FAIL glitch_strobes got %0d want 1", strobe_cnt - s0); else pass_cnt++;
        chk_cnt++; if (bus.digits_out[3:0] !== 4'd7) $display("FAIL bounce_newest got %h want 7", bus.digits_out[3:0]); else pass_cnt++;
        chk_cnt++; if (bus.digits_out !== 16'h0057) $display("FAIL bounce_digits got %h want 0057", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd2) $display("FAIL bounce_count got %0d want 2", bus.entry_count); else pass_cnt++;
    endtask

    task automatic test_sequence();
        int s0;
        logic [15:0] val;
        logic [3:0]  dig;
        pulse_clear();
        chk_cnt++; if (bus.digits_out !== 16'h0) $display("FAIL seq_clear_digits got %h want 0000", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd0) $display("FAIL seq_clear_count got %0d want 0", bus.entry_count); else pass_cnt++;
        s0 = strobe_cnt;
        press(4'd1, 12, 12);
        press(4'd2, 12, 12);
        press(4'd3, 12, 12);
        press(4'd4, 12, 12);
        chk_cnt++; if (bus.digits_out !== 16'h1234) $display("FAIL seq4_digits got %h want 1234", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd4) $display("FAIL seq4_count got %0d want 4", bus.entry_count); else pass_cnt++;
        chk_cnt++; if (bus.overflow !== 1'b0) $display("FAIL seq4_overflow got %b want 0", bus.overflow); else pass_cnt++;
        press(4'd9, 12, 12);
        chk_cnt++; if (bus.digits_out !== 16'h2349) $display("FAIL seq5_digits got %h want 2349", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd4) $display("FAIL seq5_count got %0d want 4", bus.entry_count); else pass_cnt++;
        chk_cnt++; if (bus.overflow !== 1'b1) $display("FAIL seq5_overflow got %b want 1", bus.overflow); else pass_cnt++;
        chk_cnt++; if (strobe_cnt - s0 !== 5) $display("FAIL seq_strobes got %0d want 5", strobe_cnt - s0); else pass_cnt++;
        val = 16'h2349;
        for (int k = 0; k < 32; k++) begin
            tick(1);
            case (bus.an_n)
                4'b1110: dig = val[3:0];
                4'b1101: dig = val[7:4];
                4'b1011: dig = val[11:8];
                default: dig = val[15:12];
            endcase
            chk_cnt++; if (bus.seg_n !== seg_of(dig)) $display("FAIL full_seg an %b got %b want %b", bus.an_n, bus.seg_n, seg_of(dig)); else pass_cnt++;
        end
    endtask

    task automatic test_clear_capture();
        int s0;
        pulse_clear();
        chk_cnt++; if (bus.overflow !== 1'b0) $display("FAIL clr_overflow got %b want 0", bus.overflow); else pass_cnt++;
        press(4'd1, 12, 12);
        press(4'd2, 12, 12);
        chk_cnt++; if (bus.digits_out !== 16'h0012) $display("FAIL clr_pre_digits got %h want 0012", bus.digits_out); else pass_cnt++;
        s0 = strobe_cnt;
        bus.bcd_in    = 4'd8;
        bus.key_valid = 1'b1;
        tick(6);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        chk_cnt++; if (bus.digits_out !== 16'h0) $display("FAIL clrcap_digits got %h want 0000", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd0) $display("FAIL clrcap_count got %0d want 0", bus.entry_count); else pass_cnt++;
        chk_cnt++; if (bus.digit_strobe !== 1'b0) $display("FAIL clrcap_strobe got %b want 0", bus.digit_strobe); else pass_cnt++;
        tick(20);
        bus.key_valid = 1'b0;
        tick(20);
        chk_cnt++; if (strobe_cnt - s0 !== 0) $display("FAIL clr_held_strobes got %0d want 0", strobe_cnt - s0); else pass_cnt++;
        chk_cnt++; if (bus.digits_out !== 16'h0) $display("FAIL clr_held_digits got %h want 0000", bus.digits_out); else pass_cnt++;
        press(4'd8, 20, 20);
        chk_cnt++; if (bus.digits_out !== 16'h0008) $display("FAIL clr_repress_digits got %h want 0008", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd1) $display("FAIL clr_repress_count got %0d want 1", bus.entry_count); else pass_cnt++;
        chk_cnt++; if (strobe_cnt - s0 !== 1) $display("FAIL clr_repress_strobes got %0d want 1", strobe_cnt - s0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int s0;
        bus.bcd_in    = 4'd6;
        bus.key_valid = 1'b1;
        tick(4);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_press_chk");
        bus.key_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        s0 = strobe_cnt;
        tick(20);
        chk_cnt++; if (strobe_cnt - s0 !== 0) $display("FAIL rst_pc_strobes got %0d want 0", strobe_cnt - s0); else pass_cnt++;
        bus.key_valid = 1'b1;
        tick(10);
        chk_cnt++; if (bus.digits_out !== 16'h0006) $display("FAIL rst_pre_held_digits got %h want 0006", bus.digits_out); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if (bus.digits_out !== 16'h0) $display("FAIL rst_held_digits got %h want 0000", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd0) $display("FAIL rst_held_count got %0d want 0", bus.entry_count); else pass_cnt++;
        bus.key_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        press(4'd3, 20, 20);
        chk_cnt++; if (bus.digits_out !== 16'h0003) $display("FAIL rst_after_digits got %h want 0003", bus.digits_out); else pass_cnt++;
        chk_cnt++; if (bus.entry_count !== 3'd1) $display("FAIL rst_after_count got %0d want 1", bus.entry_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_sequence();
        test_clear_capture();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
